// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU clients and alu_arbiter.
// Requester i uses bit i of each 2-bit valid/ready vector.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req_ctrl0;
  logic [2:0]       req_ctrl1;
  logic [SHW-1:0]   req_num0;
  logic [SHW-1:0]   req_num1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_y;

  modport master (
    output req_valid, req_ctrl0, req_ctrl1, req_num0, req_num1,
           req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_ctrl0, req_ctrl1, req_num0, req_num1,
           req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Operands are registered toward the ALU; the result returns on a registered response.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHW     = 5,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [2:0]       alu_ctrl,
  output logic [SHW-1:0]   alu_num,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy,
  output logic             grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t     state, state_nxt;
  logic       rr_ptr;
  logic       sel;
  logic       accept;
  logic       exec_done;
  logic       rsp_hs;
  logic [3:0] cnt;

  // A lone requester wins outright; the pointer only breaks ties.
  function automatic logic pick(input logic [1:0] vld, input logic ptr);
    return (vld == 2'b11) ? ptr : vld[1];
  endfunction

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    accept        = 1'b0;
    exec_done     = 1'b0;
    rsp_hs        = 1'b0;
    sel           = pick(bus.req_valid, rr_ptr);
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          accept        = 1'b1;
          bus.req_ready = sel ? 2'b10 : 2'b01;
          state_nxt     = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          exec_done = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = grant_id ? 2'b10 : 2'b01;
        if (bus.rsp_ready[grant_id]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      grant_id  <= 1'b0;
      cnt       <= 4'd0;
      alu_ctrl  <= 3'd0;
      alu_num   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      bus.rsp_y <= '0;
    end else begin
      state <= state_nxt;
      // Accept -> EXEC boundary: the winner's payload is frozen for the ALU.
      if (accept) begin
        grant_id <= sel;
        cnt      <= CNT_INIT;
        alu_ctrl <= sel ? bus.req_ctrl1 : bus.req_ctrl0;
        alu_num  <= sel ? bus.req_num1  : bus.req_num0;
        alu_a    <= sel ? bus.req_a1    : bus.req_a0;
        alu_b    <= sel ? bus.req_b1    : bus.req_b0;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // EXEC -> RESP boundary: sample the ALU on its last settled cycle.
      if (exec_done) bus.rsp_y <= alu_y;
      if (rsp_hs) rr_ptr <= ~grant_id;
    end
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (ctrl[2:0], shift amount num[4:0], operands a and b, result y) between two requesters.
- Each requester issues an operation through a valid/ready request channel and receives the registered result on a valid/ready response channel.
- When both requesters are valid, a round-robin pointer picks the winner.
- Sits between the ALU instance and its two clients (e.g. a sequencer and a host port).

Parameters:
- WIDTH, 32, operand/result width.
- SHW, 5, shift-amount width (log2 WIDTH).
- ALU_LAT, 1, cycles ALU inputs are held before y is captured; legal values are 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_ctrl0, req_ctrl1  in  3  ALU opcode per requester.
- req_num0, req_num1  in  SHW  shift amount per requester.
- req_a0, req_a1, req_b0, req_b1  in  WIDTH  operands.
- rsp_valid  out  2  result valid for requester i; one-hot or zero.
- rsp_ready  in  2  requester i accepts result.
- rsp_y  out  WIDTH  result, shared by both requesters; qualified by rsp_valid.
- alu_ctrl  out  3  to ALU, registered.
- alu_num  out  SHW  to ALU, registered.
- alu_a, alu_b  out  WIDTH  to ALU, registered.
- alu_y  in  WIDTH  from ALU (combinational).
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester currently owning the ALU; valid while busy.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0 (requester 0 preferred), alu_ctrl/num/a/b=0, rsp_y=0, rsp_valid=0, busy=0, grant_id=0, exec counter=0. An in-flight operation is discarded; no response is produced.
- req_ready is combinational: it is asserted only in IDLE, and only for the selected requester.
- Selection in IDLE:
  - Only one req_valid bit set: that requester wins, regardless of rr_ptr.
  - Both set: requester rr_ptr wins.
  - None set: stay in IDLE.
- Accept cycle T (IDLE, req_valid[g] & req_ready[g]): latch the requester's ctrl/num/a/b into the alu_* registers, set grant_id=g, load counter=ALU_LAT-1, go EXEC.
- EXEC (cycles T+1 .. T+ALU_LAT):
  - alu_* outputs stay constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture alu_y into rsp_y and go RESP.
- RESP (from T+ALU_LAT+1):
  - rsp_valid[grant_id]=1; rsp_y is stable.
  - Stay in RESP while rsp_ready[grant_id]=0. No timeout; a stalled response blocks the other requester.
  - On rsp_valid & rsp_ready: set rr_ptr = ~grant_id, go IDLE, rsp_valid drops next cycle.
  - rsp_ready of the non-granted requester is ignored.
- Throughput: one operation per ALU_LAT+2 cycles at most (accept, ALU_LAT exec, response). There is no back-to-back accept in the response-handshake cycle.
- Requesters hold valid and payload stable until ready. Payload changes after the accept cycle have no effect.
- req_valid deasserting before acceptance is tolerated: no grant, no state change.
- req_valid asserted by the non-granted requester during EXEC/RESP: req_ready stays 0; the request is served in IDLE afterwards. With both valid continuously, grants strictly alternate 0,1,0,1.
- The arbiter does not interpret opcodes. Any ctrl value 000..111 passes through, and rsp_y = alu_y sampled at the last EXEC cycle.

Test Plan:
- Reset state: assert rst mid-EXEC (ALU_LAT=3, second EXEC cycle) -> all outputs 0 immediately (async), state IDLE. After release, no rsp_valid appears.
- Single request, ALU_LAT=1, alu_y stubbed to a^b:
  - Stimulus: req0 with ctrl=3'b010, num=5, a=30, b=90, valid at cycle T.
  - Required: req_ready[0]=1 at T; alu_ctrl=010, alu_num=5, alu_a=30, alu_b=90 from T+1; rsp_valid=2'b01 with rsp_y=68 at T+2; rsp_ready at T+2 -> idle at T+3.
- Contention, both valid every cycle, ALU_LAT=1, rsp_ready tied high:
  - req0 a=1, req1 a=2.
  - Required: grants alternate 0,1,0,1 starting with 0; one accept every 3 cycles.
  - Each rsp_valid bit matches the grant that produced it.
- Response backpressure:
  - Hold rsp_ready[1]=0 for 10 cycles after rsp_valid[1] rises, while req0 is valid.
  - Required: rsp_valid=2'b10 and rsp_y stay stable; req_ready=0 throughout; req0 is accepted in the cycle after the handshake.
- Latency parameter: ALU_LAT=4, single request from req1 at T -> alu_* stable T+1..T+4; rsp_valid[1] at T+5; busy high T+1..handshake.
- Opcode sweep: req0 issues ctrl 000 through 111 with a=30, b=90, num=5, rsp_ready high -> eight responses in order. Each rsp_y equals the reference ALU model output for that ctrl, matching the standalone ALU results.
